// File: rtl/inst_rom_loader_pkg.sv
// Shared bus widths, reset polarity and state encoding for the instruction ROM loader.
// Stands in for the old defines.v macros so every file sees the same constants through one import.
package inst_rom_loader_pkg;

    localparam int REG_BUS_W         = 32;
    localparam int INST_ADDR_BUS_W   = 32;
    localparam int INST_BUS_W        = 32;
    localparam int BYTE_W            = 8;
    localparam int BYTES_PER_WORD    = INST_BUS_W / BYTE_W;

    localparam int INST_MEM_NUM_LOG2 = 10;

    // Polarity expected by the openmips core on its reset input.
    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } ld_state_e;

    // Stream slot that lands in byte lane 'lane' (lane 0 = bits [7:0]).
    function automatic logic [1:0] lane_slot(input int lane, input bit big_endian);
        logic [1:0] slot;
        slot = big_endian ? 2'(BYTES_PER_WORD - 1 - lane) : 2'(lane);
        return slot;
    endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream loader handshake: the image source is the master, the ROM loader the slave.
interface inst_rom_loader_if;
    import inst_rom_loader_pkg::*;

    logic              ld_valid;
    logic [BYTE_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/inst_rom_loader_mem.sv
// Instruction word array: synchronous write port for the loader, asynchronous read for the fetch path.
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int AW = INST_MEM_NUM_LOG2,
    parameter int DW = INST_BUS_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 2 ** AW;

    // Contents survive reset so a reload simply overwrites them.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Loads a program image from a byte stream into the instruction array while holding the CPU
// in reset, then releases the CPU and answers its fetches combinationally.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ROM_AW     = INST_MEM_NUM_LOG2,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    inst_rom_loader_if.slave           ld,
    input  logic                       rom_ce_i,
    input  logic [INST_ADDR_BUS_W-1:0] rom_addr_i,
    output logic [INST_BUS_W-1:0]      rom_data_o,
    output logic                       cpu_rst_o,
    output logic                       load_done_o,
    output logic                       ld_err_o,
    output logic [ROM_AW:0]            load_words_o
);

    ld_state_e             state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ROM_AW:0]       waddr_q, waddr_d;
    logic [INST_BUS_W-1:0] word_buf_q, word_buf_d;
    logic                  err_q, err_d;
    logic                  done_q;

    logic                  xfer;
    logic                  wr_req;
    logic                  full;
    logic                  mem_we;
    logic [INST_BUS_W-1:0] word_fill;
    logic [INST_BUS_W-1:0] rd_word;

    assign xfer   = ld.ld_valid && (state_q == S_LOAD);
    assign wr_req = xfer && ((byte_cnt_q == 2'd3) || ld.ld_last);
    // waddr saturates at the depth, so the top bit alone marks an exhausted array.
    assign full   = waddr_q[ROM_AW];
    assign mem_we = wr_req && !full;

    // Slots beyond the current one are still zero in word_buf_q, which gives the
    // zero padding of a short final word for free.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        localparam logic [1:0] SLOT = lane_slot(gi, BIG_ENDIAN);
        assign word_fill[gi*BYTE_W +: BYTE_W] =
            (byte_cnt_q == SLOT) ? ld.ld_data : word_buf_q[gi*BYTE_W +: BYTE_W];
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        waddr_d    = waddr_q;
        word_buf_d = word_buf_q;
        err_d      = err_q;
        if (xfer) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_buf_d = word_fill;
            if (wr_req) begin
                byte_cnt_d = 2'd0;
                word_buf_d = '0;
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    waddr_d = waddr_q + 1'b1;
                end
            end
            if (ld.ld_last) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            byte_cnt_q <= 2'd0;
            waddr_q    <= '0;
            word_buf_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            waddr_q    <= waddr_d;
            word_buf_q <= word_buf_d;
            err_q      <= err_d;
            // Release lags the final write by one cycle so the word is settled first.
            done_q     <= (state_q == S_RUN);
        end
    end

    inst_rom_mem #(
        .AW (ROM_AW),
        .DW (INST_BUS_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (waddr_q[ROM_AW-1:0]),
        .wdata_i (word_fill),
        .raddr_i (rom_addr_i[ROM_AW+1:2]),
        .rdata_o (rd_word)
    );

    // Byte offset and high address bits play no part in the lookup.
    logic unused_addr;
    assign unused_addr = ^{rom_addr_i[INST_ADDR_BUS_W-1:ROM_AW+2], rom_addr_i[1:0]};

    assign ld.ld_ready   = (state_q == S_LOAD);
    assign rom_data_o    = ((state_q == S_RUN) && rom_ce_i) ? rd_word : '0;
    assign cpu_rst_o     = done_q ? RST_DISABLE : RST_ENABLE;
    assign load_done_o   = done_q;
    assign ld_err_o      = err_q;
    assign load_words_o  = waddr_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench: one byte stream drives a big-endian, a little-endian and a 4-word loader in parallel.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v   = 1'b0;
    logic [7:0]  d   = 8'h00;
    logic        l   = 1'b0;
    logic        ce  = 1'b0;
    logic [31:0] ra  = 32'h0;

    logic [31:0] rd0, rd1, rd2;
    logic        crst0, crst1, crst2;
    logic        done0, done1, done2;
    logic        err0, err1, err2;
    logic [10:0] lw0, lw1;
    logic [2:0]  lw2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_rom_loader_if bus0();
    inst_rom_loader_if bus1();
    inst_rom_loader_if bus2();

    assign bus0.ld_valid = v;  assign bus0.ld_data = d;  assign bus0.ld_last = l;
    assign bus1.ld_valid = v;  assign bus1.ld_data = d;  assign bus1.ld_last = l;
    assign bus2.ld_valid = v;  assign bus2.ld_data = d;  assign bus2.ld_last = l;

    inst_rom_loader #(.ROM_AW(10), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .ld(bus0.slave), .rom_ce_i(ce), .rom_addr_i(ra),
        .rom_data_o(rd0), .cpu_rst_o(crst0), .load_done_o(done0), .ld_err_o(err0),
        .load_words_o(lw0)
    );

    inst_rom_loader #(.ROM_AW(10), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .ld(bus1.slave), .rom_ce_i(ce), .rom_addr_i(ra),
        .rom_data_o(rd1), .cpu_rst_o(crst1), .load_done_o(done1), .ld_err_o(err1),
        .load_words_o(lw1)
    );

    inst_rom_loader #(.ROM_AW(2), .BIG_ENDIAN(1'b1)) dut_small (
        .clk(clk), .rst(rst), .ld(bus2.slave), .rom_ce_i(ce), .rom_addr_i(ra),
        .rom_data_o(rd2), .cpu_rst_o(crst2), .load_done_o(done2), .ld_err_o(err2),
        .load_words_o(lw2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        v   = 1'b0;
        l   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        v = 1'b1;
        d = b;
        l = last;
        @(posedge clk);
        #1;
        v = 1'b0;
        l = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input int which, input logic [31:0] addr,
                             input logic [31:0] exp);
        @(negedge clk);
        ce = 1'b1;
        ra = addr;
        #1;
        case (which)
            0:       check_eq(tag, rd0, exp);
            1:       check_eq(tag, rd1, exp);
            default: check_eq(tag, 32'(rd2), exp);
        endcase
        ce = 1'b0;
    endtask

    task automatic send_img1(input bit gap);
        logic [7:0] img [8];
        img = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
        for (int i = 0; i < 8; i++) begin
            if (gap && i == 2) begin
                repeat (10) @(negedge clk);
                check_eq("gap_ready", 32'(bus0.ld_ready), 32'h1);
                check_eq("gap_words", 32'(lw0), 32'h0);
            end
            send_byte(img[i], i == 7);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset state, then the two-word image.
        @(posedge clk);
        @(negedge clk);
        ce = 1'b1;
        #1;
        check_eq("rst_ready", 32'(bus0.ld_ready), 32'h1);
        check_eq("rst_cpu_rst", 32'(crst0), 32'h1);
        check_eq("rst_done", 32'(done0), 32'h0);
        check_eq("rst_words", 32'(lw0), 32'h0);
        check_eq("rst_err", 32'(err0), 32'h0);
        check_eq("rst_rom_data", rd0, 32'h0);
        ce = 1'b0;
        rst = 1'b1;

        send_img1(1'b0);
        check_eq("t1_cpu_rst_held", 32'(crst0), 32'h1);
        check_eq("t1_done_held", 32'(done0), 32'h0);
        check_eq("t1_words", 32'(lw0), 32'h2);
        check_eq("t1_ready_low", 32'(bus0.ld_ready), 32'h0);
        @(posedge clk);
        #1;
        check_eq("t1_cpu_rst_fall", 32'(crst0), 32'h0);
        check_eq("t1_done_rise", 32'(done0), 32'h1);

        // Test 2: fetches.
        fetch_chk("t2_mem0", 0, 32'h0, 32'h34020001);
        fetch_chk("t2_addr4", 0, 32'h4, 32'h34030002);
        fetch_chk("t2_addr5", 0, 32'h5, 32'h34030002);
        fetch_chk("t2_le_mem0", 1, 32'h0, 32'h01000234);
        @(negedge clk);
        ce = 1'b0;
        ra = 32'h4;
        #1;
        check_eq("t2_ce0", rd0, 32'h0);

        // Test 3: short final word, both byte orders; loader ignored afterwards.
        do_reset();
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0); send_byte(8'hEE, 1'b0); send_byte(8'hFF, 1'b1);
        check_eq("t3_words", 32'(lw0), 32'h2);
        repeat (2) @(posedge clk);
        fetch_chk("t3_be_mem0", 0, 32'h0, 32'hAABBCCDD);
        fetch_chk("t3_be_mem1", 0, 32'h4, 32'hEEFF0000);
        fetch_chk("t3_le_mem0", 1, 32'h0, 32'hDDCCBBAA);
        fetch_chk("t3_le_mem1", 1, 32'h4, 32'h0000FFEE);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
        check_eq("t3_run_words", 32'(lw0), 32'h2);
        fetch_chk("t3_run_mem0", 0, 32'h0, 32'hAABBCCDD);

        // Test 4: 20 bytes into the 4-word instance overflow once.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i + 1), i == 19);
            if (i == 15) begin
                check_eq("t4_err_before", 32'(err2), 32'h0);
                check_eq("t4_words_full", 32'(lw2), 32'h4);
            end
        end
        check_eq("t4_err_set", 32'(err2), 32'h1);
        check_eq("t4_words_sat", 32'(lw2), 32'h4);
        check_eq("t4_big_err", 32'(err0), 32'h0);
        check_eq("t4_big_words", 32'(lw0), 32'h5);
        @(posedge clk);
        #1;
        check_eq("t4_done", 32'(done2), 32'h1);
        fetch_chk("t4_mem0", 2, 32'h0, 32'h01020304);
        fetch_chk("t4_mem1", 2, 32'h4, 32'h05060708);
        fetch_chk("t4_mem2", 2, 32'h8, 32'h090A0B0C);
        fetch_chk("t4_mem3", 2, 32'hC, 32'h0D0E0F10);
        fetch_chk("t4_alias", 2, 32'h10, 32'h01020304);
        fetch_chk("t4_big_mem4", 0, 32'h10, 32'h11121314);
        fetch_chk("t4_big_alias", 0, 32'h1000, 32'h01020304);

        // Test 5: stalled stream.
        do_reset();
        check_eq("t5_err_cleared", 32'(err2), 32'h0);
        send_img1(1'b1);
        check_eq("t5_words", 32'(lw0), 32'h2);
        repeat (2) @(posedge clk);
        fetch_chk("t5_mem0", 0, 32'h0, 32'h34020001);
        fetch_chk("t5_mem1", 0, 32'h4, 32'h34030002);

        // Test 6: reset in the middle of a load discards the partial word.
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'hFF, 1'b0);
        check_eq("t6_words_mid", 32'(lw0), 32'h1);
        check_eq("t6_cpu_rst_mid", 32'(crst0), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6_cpu_rst_rst", 32'(crst0), 32'h1);
        check_eq("t6_words_rst", 32'(lw0), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send_img1(1'b0);
        check_eq("t6_cpu_rst_end", 32'(crst0), 32'h1);
        check_eq("t6_words", 32'(lw0), 32'h2);
        repeat (2) @(posedge clk);
        fetch_chk("t6_mem0", 0, 32'h0, 32'h34020001);
        fetch_chk("t6_mem1", 0, 32'h4, 32'h34030002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
